// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants and types for the IF->ID fetch queue.
package fetch_queue_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_W     = 32;
    localparam int FQ_DEPTH = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One queued fetch: PC in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage : fetch_queue_pkg

// File: rtl/fq_mem.sv
// Fetch-queue storage: synchronous write at tail, asynchronous read at head.
module fq_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fq_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output fq_entry_t       rdata
);

    fq_entry_t mem_q [DEPTH];

    // Write the pushed entry; contents are never reset, occupancy lives in the control.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fq_mem

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: buffers {pc, instr} pairs,
// presents the oldest to ID and drops everything on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     validf,
    input  logic [INSTR_W-1:0]       instrf,
    input  logic [PC_W-1:0]          pcf,
    output logic                     fullf,
    input  logic                     flushd,
    input  logic                     stalld,
    output logic                     validd,
    output logic [INSTR_W-1:0]       instrd,
    output logic [PC_W-1:0]          pcd,
    output logic [$clog2(DEPTH):0]   countq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic      push;
    logic      pop;
    fq_entry_t wr_entry;
    fq_entry_t head_entry;

    // Full and valid come from registered occupancy only, so IF never sees
    // a combinational path through the same-cycle pop.
    assign fullf  = (count_q == FULL_CNT);
    assign validd = (count_q != '0);
    assign countq = count_q;

    assign wr_entry.pc    = pcf;
    assign wr_entry.instr = instrf;

    // Handshakes, then next pointer/count; a flush overrides any push or pop.
    always_comb begin
        push    = validf & ~fullf & ~flushd;
        pop     = validd & ~stalld & ~flushd;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flushd) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (head_entry)
    );

    // An empty queue presents a NOP at PC 0 rather than stale array contents.
    assign instrd = validd ? head_entry.instr : NOP_INSTR;
    assign pcd    = validd ? head_entry.pc    : '0;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        validf;
    logic [31:0] instrf;
    logic [31:0] pcf;
    logic        fullf;
    logic        flushd;
    logic        stalld;
    logic        validd;
    logic [31:0] instrd;
    logic [31:0] pcd;
    logic [2:0]  countq;

    int n_checks;
    int n_errors;

    fetch_queue #(.DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .validf (validf),
        .instrf (instrf),
        .pcf    (pcf),
        .fullf  (fullf),
        .flushd (flushd),
        .stalld (stalld),
        .validd (validd),
        .instrd (instrd),
        .pcd    (pcd),
        .countq (countq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc);
        validf = 1'b1;
        pcf    = pc;
        instrf = 32'h2400_0000 | pc;
        step();
        validf = 1'b0;
    endtask

    logic [31:0] np;
    logic [31:0] eh;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b0;
        validf = 1'b0;
        instrf = '0;
        pcf    = '0;
        flushd = 1'b0;
        stalld = 1'b0;

        // Reset and empty
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_validd", 32'(validd), 32'd0);
        check("rst_instrd", instrd, 32'd0);
        check("rst_pcd",    pcd,    32'd0);
        check("rst_fullf",  32'(fullf), 32'd0);
        check("rst_countq", 32'(countq), 32'd0);

        // Single push then pop, no bypass
        validf = 1'b1;
        pcf    = 32'h0000_3000;
        instrf = 32'h2008_0005;
        check("nobypass_validd", 32'(validd), 32'd0);
        step();
        validf = 1'b0;
        check("single_validd", 32'(validd), 32'd1);
        check("single_pcd",    pcd,    32'h0000_3000);
        check("single_instrd", instrd, 32'h2008_0005);
        check("single_count",  32'(countq), 32'd1);
        step();
        check("single_popped", 32'(validd), 32'd0);
        check("single_nop",    instrd, 32'd0);

        // Fill to full under stall; fifth push refused
        stalld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_one(32'h3000 + 32'(4 * i));
        end
        check("fill_count", 32'(countq), 32'd4);
        check("fill_fullf", 32'(fullf), 32'd1);
        check("fill_head",  pcd, 32'h0000_3000);
        // Full with stall released: pop happens, push of 0x3010 is refused
        stalld = 1'b0;
        push_one(32'h0000_3010);
        check("full_refuse_count", 32'(countq), 32'd3);
        check("full_refuse_head",  pcd, 32'h0000_3004);
        check("full_refuse_fullf", 32'(fullf), 32'd0);
        // IF retries 0x3010 while ID stalls
        stalld = 1'b1;
        push_one(32'h0000_3010);
        check("retry_count", 32'(countq), 32'd4);
        stalld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_pcd", pcd, 32'h3004 + 32'(4 * i));
            step();
        end
        check("drain_empty", 32'(validd), 32'd0);

        // Simultaneous push/pop at count=2, wrapping past index 3
        stalld = 1'b1;
        push_one(32'h0000_5000);
        push_one(32'h0000_5004);
        check("pp_count_init", 32'(countq), 32'd2);
        check("pp_head_init",  pcd, 32'h0000_5000);
        stalld = 1'b0;
        np = 32'h0000_5008;
        eh = 32'h0000_5000;
        for (int k = 0; k < 10; k++) begin
            push_one(np);
            np = np + 32'd4;
            eh = eh + 32'd4;
            check("pp_count", 32'(countq), 32'd2);
            check("pp_pcd",   pcd, eh);
        end
        check("pp_instrd", instrd, 32'h2400_0000 | eh);
        step();
        check("pp_drain1", pcd, eh + 32'd4);
        step();
        check("pp_drained", 32'(validd), 32'd0);

        // Flush with 3 queued and a simultaneous fetch
        stalld = 1'b1;
        push_one(32'h0000_6000);
        push_one(32'h0000_6004);
        push_one(32'h0000_6008);
        check("pre_flush_count", 32'(countq), 32'd3);
        flushd = 1'b1;
        stalld = 1'b0;
        push_one(32'h0000_3100);
        flushd = 1'b0;
        check("flush_count",  32'(countq), 32'd0);
        check("flush_validd", 32'(validd), 32'd0);
        check("flush_fullf",  32'(fullf), 32'd0);
        check("flush_pcd",    pcd, 32'd0);
        stalld = 1'b1;
        push_one(32'h0000_4000);
        check("post_flush_validd", 32'(validd), 32'd1);
        check("post_flush_pcd",    pcd, 32'h0000_4000);
        check("post_flush_count",  32'(countq), 32'd1);

        // Async reset between edges
        push_one(32'h0000_4004);
        push_one(32'h0000_4008);
        check("pre_areset_count", 32'(countq), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("areset_count",  32'(countq), 32'd0);
        check("areset_validd", 32'(validd), 32'd0);
        check("areset_pcd",    pcd, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("after_areset_empty", 32'(validd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the IF stage and the ID stage of the 5-stage MIPS pipeline.
- Buffers up to DEPTH {pc, instr} pairs produced by IF, so short decode stalls do not freeze the PC immediately.
- Presents the oldest entry to ID and discards all entries on a control-flow redirect (flush).

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- AW, log2(DEPTH) = 2, pointer width; derived, not overridden.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- validf  input  1  IF presents a fetched instruction this cycle.
- instrf  input  32  instruction word from IF.
- pcf  input  32  PC of instrf.
- fullf  output  1  queue cannot accept; IF holds its PC while high.
- flushd  input  1  redirect taken (pcchangef); discard all queued entries.
- stalld  input  1  ID cannot consume this cycle.
- validd  output  1  head entry is valid for ID.
- instrd  output  32  head instruction to ID.
- pcd  output  32  PC of the head instruction.
- countq  output  AW+1  occupancy, 0..DEPTH, for debug/perf.

Behaviour:
- State: entry array of DEPTH x 64 bits, head pointer (AW bits), tail pointer (AW bits), count (AW+1 bits).
- Reset (reset=0, asynchronous): head=0, tail=0, count=0. Outputs are then validd=0, instrd=0, pcd=0, fullf=0, countq=0. Array contents are not reset.
- fullf = (count == DEPTH). Combinational from registered count only; it does not depend on the same-cycle pop.
- push = validf & ~fullf & ~flushd.
- pop = validd & ~stalld & ~flushd.
- validd = (count != 0).
- instrd and pcd show the head entry when validd=1. They are forced to 32'h0 when the queue is empty, so a NOP is presented.
- Latency: a pushed entry appears on instrd/pcd the cycle after the push edge. There is no same-cycle bypass from instrf to instrd.
- Push: write {pcf, instrf} at tail; tail = tail+1, modulo DEPTH (natural wrap).
- Pop: head = head+1, modulo DEPTH.
- Count update:
  - push and pop in the same cycle: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Full queue with stalld=0: pop occurs but push is refused that cycle, because fullf is already high. IF retries next cycle.
- Empty queue: pop is impossible because validd=0. A push into an empty queue shows at the head on the next cycle.
- Flush (flushd=1) at the edge: head=0, tail=0, count=0. Any simultaneous validf/push and pop are ignored.
  - Next cycle: validd=0, fullf=0.
  - Branch delay-slot preservation is not this block's concern; the hazard logic times flushd accordingly.
- Flush has priority over push and pop. reset has priority over everything.
- Reset deassertion mid-operation: the queue starts empty; any entries present at reset assertion are lost.

Decomposition:
- Shared package: INSTR_W=32, PC_W=32, NOP_INSTR=32'h0000_0000. DEPTH default lives as a pipeline constant there.
- Sub-module fq_mem: DEPTH x 64 storage with synchronous write port and asynchronous read port indexed by head. This matches the codebase's imem style.
- Pointer and count control stay in fetch_queue.

Test Plan:
- Reset and empty: reset=0 for 2 cycles, then 1 -> validd=0, instrd=0, pcd=0, fullf=0, countq=0.
- Single push/pop: push pcf=0x00003000, instrf=0x20080005 with stalld=0 -> next cycle validd=1, pcd=0x00003000, instrd=0x20080005; the following cycle validd=0.
- Fill to full: stalld=1, push 5 consecutive PCs 0x3000..0x3010 -> the first 4 are accepted, countq=4, fullf=1; 0x3010 is refused and must be retried. Release stalld -> entries pop in order 0x3000, 0x3004, 0x3008, 0x300C.
- Simultaneous push/pop at count=2: count stays 2 and order is preserved. Also cover the tail/head wrap past index 3 over 10 sequential instructions: pcd must increment by 4 every cycle, with no gap or duplicate.
- Flush: with 3 entries queued, assert flushd together with validf=1 (pcf=0x3100) -> next cycle countq=0, validd=0; 0x3100 is not enqueued. The following push of 0x4000 appears at the head one cycle later.
- Async reset mid-operation: with countq=3, drop reset between clock edges -> countq=0 and validd=0 immediately, without waiting for a clock edge.
